// File: rtl/matrix_display_sequencer.sv
// Collects one result matrix from a valid/ready stream, then shows each element for a fixed dwell.
// Optional: define MATRIX_DISPLAY_REPEAT_EN to loop the display until flush_i instead of returning to FILL.
//
// state | meaning
// FILL  | accepting elements into the buffer, ready_o high
// SHOW  | presenting buf[index] for dwell_cycles_p cycles each, ready_o low
module matrix_display_sequencer #(
    parameter int width_p        = 8,
    parameter int depth_p        = 4,
    parameter int dwell_cycles_p = 60000000
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    input  logic                       skip_i,
    input  logic                       flush_i,
    output logic                       display_o,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(depth_p):0]   index_o,
    output logic                       done_o
);

    localparam int IW = $clog2(depth_p) + 1;
    localparam int AW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int DW = $clog2(dwell_cycles_p + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(depth_p - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(dwell_cycles_p - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IW-1:0]      count_q, count_d;
    logic [IW-1:0]      index_q, index_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [width_p-1:0] data_q,  data_d;
    logic               done_q,  done_d;
    logic               wr_en;
    logic [AW-1:0]      rd_nxt;

    logic [width_p-1:0] buf_q [depth_p];

    assign rd_nxt = index_q[AW-1:0] + AW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        dwell_d = dwell_q;
        data_d  = data_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        if (flush_i) begin
            state_d = ST_FILL;
            count_d = '0;
            index_d = '0;
            dwell_d = '0;
            data_d  = '0;
        end else if (state_q == ST_FILL) begin
            if (valid_i) begin
                wr_en   = 1'b1;
                count_d = count_q + IW'(1);
                if (count_q == LAST_IDX) begin
                    state_d = ST_SHOW;
                    count_d = '0;
                    index_d = '0;
                    dwell_d = '0;
                    // the element being written now is buf[0] only for a single-entry matrix
                    data_d  = (depth_p == 1) ? data_i : buf_q[0];
                end
            end
        end else begin
            if (skip_i || (dwell_q == DWELL_LAST)) begin
                dwell_d = '0;
                if (index_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    index_d = '0;
`ifdef MATRIX_DISPLAY_REPEAT_EN
                    data_d  = buf_q[0];
`else
                    state_d = ST_FILL;
                    data_d  = '0;
`endif
                end else begin
                    index_d = index_q + IW'(1);
                    data_d  = buf_q[rd_nxt];
                end
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_FILL;
            count_q <= '0;
            index_q <= '0;
            dwell_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // buffer contents are don't-care after reset, so no reset branch
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            buf_q[count_q[AW-1:0]] <= data_i;
        end
    end

    assign ready_o   = (state_q == ST_FILL);
    assign display_o = (state_q == ST_SHOW);
    assign data_o    = display_o ? data_q  : '0;
    assign index_o   = display_o ? index_q : '0;
    assign done_o    = done_q;

endmodule

// File: tb/tb_matrix_display_sequencer.sv
// Bench for matrix_display_sequencer: queue-based model checked every cycle, directed cases plus random traffic.
module tb_matrix_display_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int DWELL = 10;

    logic           clk_i;
    logic           reset_n_i;
    logic           valid_i;
    logic [W-1:0]   data_i;
    logic           ready_o;
    logic           skip_i;
    logic           flush_i;
    logic           display_o;
    logic [W-1:0]   data_o;
    logic [2:0]     index_o;
    logic           done_o;

    int checks = 0;
    int errors = 0;

    matrix_display_sequencer #(
        .width_p(W), .depth_p(DEPTH), .dwell_cycles_p(DWELL)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .skip_i(skip_i), .flush_i(flush_i), .display_o(display_o),
        .data_o(data_o), .index_o(index_o), .done_o(done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // model: a matrix is a queue; while showing, m_left counts cycles remaining for the current element
    bit           m_show;
    logic [W-1:0] m_mat[$];
    int           m_pos;
    int           m_left;
    bit           m_done;

    task automatic model_reset();
        m_show = 0;
        m_mat.delete();
        m_pos  = 0;
        m_left = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] d, input bit s, input bit f);
        m_done = 0;
        if (f) begin
            model_reset();
        end else if (!m_show) begin
            if (v) begin
                m_mat.push_back(d);
                if (m_mat.size() == DEPTH) begin
                    m_show = 1;
                    m_pos  = 0;
                    m_left = DWELL;
                end
            end
        end else begin
            m_left = m_left - 1;
            if (s || m_left == 0) begin
                m_left = DWELL;
                if (m_pos == DEPTH - 1) begin
                    m_done = 1;
                    m_pos  = 0;
`ifndef MATRIX_DISPLAY_REPEAT_EN
                    m_show = 0;
                    m_mat.delete();
`endif
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ready_o",   int'(ready_o),   int'(!m_show));
        chk("display_o", int'(display_o), int'(m_show));
        chk("data_o",    int'(data_o),    m_show ? int'(m_mat[m_pos]) : 0);
        chk("index_o",   int'(index_o),   m_show ? m_pos : 0);
        chk("done_o",    int'(done_o),    int'(m_done));
    endtask

    // inputs change just after the falling edge, model advances on the rising edge, compare on the next falling edge
    task automatic tick(input bit v, input logic [W-1:0] d, input bit s, input bit f);
        valid_i = v; data_i = d; skip_i = s; flush_i = f;
        @(posedge clk_i);
        model_step(v, d, s, f);
        @(negedge clk_i);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0);
    endtask

    task automatic fill4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        tick(1, a, 0, 0);
        tick(1, b, 0, 0);
        tick(1, c, 0, 0);
        tick(1, d, 0, 0);
    endtask

    int done_cnt;

    initial begin
        reset_n_i = 0; valid_i = 0; data_i = '0; skip_i = 0; flush_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("reset ready_o",   int'(ready_o),   1);
        chk("reset display_o", int'(display_o), 0);
        chk("reset data_o",    int'(data_o),    0);
        chk("reset index_o",   int'(index_o),   0);
        chk("reset done_o",    int'(done_o),    0);
        reset_n_i = 1;
        @(negedge clk_i);
        compare();

        // back-to-back fill, then 0x99 held on valid_i through the whole display
        fill4(8'h11, 8'h22, 8'h33, 8'h44);
        chk("first show data",  int'(data_o),    8'h11);
        chk("first show ready", int'(ready_o),   0);
        chk("first show disp",  int'(display_o), 1);
        for (int i = 0; i < 9; i++) tick(1, 8'h99, 0, 0);
        chk("elem0 dwell data", int'(data_o), 8'h11);
        tick(1, 8'h99, 0, 0);
        chk("elem1 data",  int'(data_o),  8'h22);
        chk("elem1 index", int'(index_o), 1);
        for (int i = 0; i < 10; i++) tick(1, 8'h99, 0, 0);
        chk("elem2 data", int'(data_o), 8'h33);
        for (int i = 0; i < 10; i++) tick(1, 8'h99, 0, 0);
        chk("elem3 data",  int'(data_o),  8'h44);
        chk("elem3 index", int'(index_o), 3);
        for (int i = 0; i < 9; i++) tick(1, 8'h99, 0, 0);
        chk("done before end", int'(done_o), 0);
        tick(1, 8'h99, 0, 0);
        chk("done pulse", int'(done_o), 1);
`ifdef MATRIX_DISPLAY_REPEAT_EN
        chk("wrap ready", int'(ready_o),   0);
        chk("wrap index", int'(index_o),   0);
        chk("wrap data",  int'(data_o),    8'h11);
        idle(1);
        chk("done single", int'(done_o), 0);
        for (int i = 0; i < 39; i++) tick(0, 8'h00, 0, 0);
        chk("second wrap done", int'(done_o), 1);
        tick(0, 8'h00, 0, 1);
`else
        chk("after done ready", int'(ready_o),   1);
        chk("after done disp",  int'(display_o), 0);
        idle(1);
        chk("done single", int'(done_o), 0);
`endif

        // early skip on the third SHOW cycle, then skip coincident with expiry
        fill4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        idle(2);
        chk("skip pre index", int'(index_o), 0);
        tick(0, 8'h00, 1, 0);
        chk("skip index", int'(index_o), 1);
        chk("skip data",  int'(data_o),  8'hA2);
        idle(9);
        chk("full dwell after skip", int'(index_o), 1);
        idle(1);
        chk("advance after skip dwell", int'(index_o), 2);
        idle(9);
        tick(0, 8'h00, 1, 0);
        chk("skip+expiry single advance", int'(index_o), 3);
        tick(0, 8'h00, 0, 1);
        chk("flush from show", int'(display_o), 0);

        // flush after two accepts; element presented with flush is dropped; fresh matrix follows
        done_cnt = 0;
        tick(1, 8'h01, 0, 0);
        tick(1, 8'h02, 0, 0);
        tick(1, 8'h77, 0, 1);
        if (done_o) done_cnt++;
        fill4(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        chk("fresh matrix data", int'(data_o), 8'hB0);
        chk("no done on flush",  done_cnt, 0);

        // asynchronous reset while showing index 2
        tick(0, 8'h00, 1, 0);
        tick(0, 8'h00, 1, 0);
        chk("pre-reset index", int'(index_o), 2);
        #2 reset_n_i = 0;
        #1;
        model_reset();
        chk("async rst display", int'(display_o), 0);
        chk("async rst data",    int'(data_o),    0);
        chk("async rst index",   int'(index_o),   0);
        chk("async rst done",    int'(done_o),    0);
        @(negedge clk_i);
        compare();
        reset_n_i = 1;
        @(negedge clk_i);
        compare();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(bit'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_display_sequencer.md
Name: matrix_display_sequencer

Overview:
- Downstream stage of the systolic array: collects one full result matrix from the array's valid/ready output stream, then shows each element on the two-digit SSD path for a fixed dwell time.
- Replaces the top-level FIFO, display flag, 5 s clock divider and edge detectors with one self-contained block.
- Single clock domain; sits between the systolic_array data_o/valid_o and the two_ssd digit inputs.

Parameters:
- width_p, 8, result element width in bits.
- depth_p, 4, number of elements per matrix (array_width_p * array_height_p); must be >= 1.
- dwell_cycles_p, 60000000, clk_i cycles each element is displayed (5 s at 12 MHz); must be >= 1.

Ports:
- clk_i  in  1  system clock (12 MHz on board).
- reset_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream element valid.
- data_i  in  width_p  upstream element.
- ready_o  out  1  block accepts an element this cycle.
- skip_i  in  1  single-cycle pulse; advance to the next element early.
- flush_i  in  1  single-cycle pulse; abort and return to FILL.
- display_o  out  1  high while in SHOW (drives the display LED).
- data_o  out  width_p  element currently displayed; 0 when not in SHOW.
- index_o  out  $clog2(depth_p)+1  index of the displayed element; 0 when not in SHOW.
- done_o  out  1  one-cycle pulse after the last element's dwell ends.

Behaviour:
- Interface: single clock clk_i; reset_n_i is asynchronous, active-low.
- Reset (asserted anywhere, including mid-FILL or mid-SHOW): state=FILL, fill count=0, index=0, dwell counter=0, ready_o=1 after release, display_o=0, data_o=0, index_o=0, done_o=0. Buffer contents are don't-care.
- State FILL:
  - ready_o=1.
  - valid_i&ready_o writes data_i into buf[count], then count increments.
  - When the depth_p-th element is accepted, the next cycle is SHOW with index=0 and dwell=0.
  - skip_i is ignored.
- State SHOW:
  - ready_o=0, so valid_i is not accepted and upstream must hold its data.
  - display_o=1; data_o=buf[index] and index_o=index, both registered and valid on the first SHOW cycle.
  - The dwell counter increments each cycle. At dwell==dwell_cycles_p-1, or on skip_i, index advances and dwell clears.
  - Expiry and skip_i in the same cycle advance the index once only.
  - Advance from the last index: done_o pulses for one cycle, state returns to FILL (count=0), data_o/index_o return to 0, and ready_o=1 on the same cycle done_o is high.
- flush_i: highest priority, from any state. Next cycle is FILL with count=0, index=0, dwell=0. No done_o. An element presented the same cycle as flush_i is dropped.
- Latency: the last accept at cycle N gives display_o=1 at N+1. Each element is shown for exactly dwell_cycles_p cycles unless skipped.
- Counter widths: dwell is $clog2(dwell_cycles_p+1) bits; the counter never wraps because it clears on advance.

Optional Feature:
- Macro: MATRIX_DISPLAY_REPEAT_EN.
- Defined: after the last element, index wraps to 0 and SHOW continues indefinitely. done_o still pulses once per pass. Only flush_i or reset returns the block to FILL; ready_o stays 0.
- Undefined: behaviour as specified above (return to FILL after one pass).

Test Plan (dwell_cycles_p=10, depth_p=4, width_p=8):
- Stream 0x11,0x22,0x33,0x44 with back-to-back valid -> ready_o drops the cycle after 0x44. data_o shows 0x11,0x22,0x33,0x44 for 10 cycles each, with index_o 0..3. done_o pulses once, then ready_o=1.
- skip_i at SHOW cycle 3 of index 0 -> index_o=1 next cycle, dwell restarts, and element 1 shows for a full 10 cycles.
- skip_i coincident with dwell expiry -> exactly one advance (0->1), not 0->2.
- Cases that must have no effect: valid_i held high with 0x99 during SHOW is never accepted and the buffer is unchanged; flush_i after 2 accepts returns to FILL, the next 4 elements fill a fresh matrix, and no done_o is produced.
- reset_n_i low asynchronously mid-SHOW (index 2) -> outputs go to reset values immediately, without a clock edge.
- MATRIX_DISPLAY_REPEAT_EN defined -> after index 3, index_o returns to 0. done_o pulses on every wrap, ready_o stays 0 until flush_i.
